bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 ("double dabble").
- Source side of the BCD digit interface. Takes an 8-bit ALU/RPN result and produces hundreds, tens and units BCD digits.
- Each digit output drives one displayDEC-style BCD→7-segment decoder (A=MSB … D=LSB of each digit).
- Start/busy/done handshake. One iteration per clock, so there is no wide combinational divider.

---
 rtl/bin_to_bcd_seq.sv | 163 ++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter: one iteration per clock, start/busy/done handshake.
// Optional two's-complement input with sign flag is enabled by defining BCD_SIGNED_EN.
module bin_to_bcd_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             START,
  input  logic [WIDTH-1:0] BIN,
  output logic [3:0]       BCD2,
  output logic [3:0]       BCD1,
  output logic [3:0]       BCD0,
  output logic             NEG,
  output logic             BUSY,
  output logic             DONE
);

  localparam int                CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  if (WIDTH < 4 || WIDTH > 9) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH must be 4..9 so the result fits three BCD digits");
  end

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [11:0]      acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bcd2_q, bcd2_d;
  logic [3:0]       bcd1_q, bcd1_d;
  logic [3:0]       bcd0_q, bcd0_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0]  load_val;
  logic [11:0]       adj;
  logic [WIDTH+11:0] shifted;

  // Every nibble of 5 or more is corrected before the shift so it carries properly after doubling.
  function automatic logic [11:0] add3(input logic [11:0] a);
    logic [11:0] r;
    r = a;
    for (int i = 0; i < 3; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign adj     = add3(acc_q);
  assign shifted = {adj, sh_q} << 1;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    bcd2_d  = bcd2_q;
    bcd1_d  = bcd1_q;
    bcd0_d  = bcd0_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          sh_d    = load_val;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = shifted[WIDTH+11:WIDTH];
        sh_d  = shifted[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          bcd2_d  = acc_d[11:8];
          bcd1_d  = acc_d[7:4];
          bcd0_d  = acc_d[3:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the datapath registers are plain flops, not a memory array, so all of them take the async reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      bcd2_q  <= '0;
      bcd1_q  <= '0;
      bcd0_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q <= state_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      bcd2_q  <= bcd2_d;
      bcd1_q  <= bcd1_d;
      bcd0_q  <= bcd0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef BCD_SIGNED_EN
  logic neg_pend_q, neg_pend_d;
  logic neg_q, neg_d;

  // The most negative code negates to itself, which read as unsigned is exactly its magnitude.
  assign load_val = BIN[WIDTH-1] ? ((~BIN) + WIDTH'(1'b1)) : BIN;

  always_comb begin
    neg_pend_d = neg_pend_q;
    neg_d      = neg_q;
    if (state_q == S_IDLE && START) neg_pend_d = BIN[WIDTH-1];
    if (done_d)                     neg_d      = neg_pend_q;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      neg_pend_q <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      neg_pend_q <= neg_pend_d;
      neg_q      <= neg_d;
    end
  end

  assign NEG = neg_q;
`else
  assign load_val = BIN;
  assign NEG      = 1'b0;
`endif

  assign BCD2 = bcd2_q;
  assign BCD1 = bcd1_q;
  assign BCD0 = bcd0_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

`ifndef SYNTHESIS
  a_digits_legal: assert property (@(posedge CLK) disable iff (!RSTN)
    (BCD2 <= 4'd9) && (BCD1 <= 4'd9) && (BCD0 <= 4'd9));
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table plus scoreboard queue popped on every DONE pulse.
// Define BCD_SIGNED_EN for both bench and RTL to exercise the signed build.
module tb_bin_to_bcd_seq;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [3:0] bcd2;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
    logic       neg;
  } expected_t;

  typedef struct packed {
    logic [7:0] bin;
    expected_t  exp;
  } vec_t;

  logic       CLK;
  logic       RSTN;
  logic       START;
  logic [7:0] BIN;
  logic [3:0] BCD2, BCD1, BCD0;
  logic       NEG, BUSY, DONE;

  int        checks;
  int        errors;
  int        done_count;
  expected_t exp_q[$];
  expected_t last_out;
  vec_t      vecs[8];

  bin_to_bcd_seq #(.WIDTH(WIDTH)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .START(START),
    .BIN  (BIN),
    .BCD2 (BCD2),
    .BCD1 (BCD1),
    .BCD0 (BCD0),
    .NEG  (NEG),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic expected_t model(input logic [7:0] b);
    expected_t e;
    int v;
    e.neg = 1'b0;
`ifdef BCD_SIGNED_EN
    if (b[7]) begin
      v     = 256 - int'(b);
      e.neg = 1'b1;
    end else begin
      v = int'(b);
    end
`else
    v = int'(b);
`endif
    e.bcd2 = 4'(v / 100);
    e.bcd1 = 4'((v / 10) % 10);
    e.bcd0 = 4'(v % 10);
    return e;
  endfunction

  function automatic vec_t mk(input logic [7:0] b, input int d2, input int d1, input int d0, input bit n);
    vec_t v;
    v.bin      = b;
    v.exp.bcd2 = 4'(d2);
    v.exp.bcd1 = 4'(d1);
    v.exp.bcd0 = 4'(d0);
    v.exp.neg  = n;
    return v;
  endfunction

  // Scoreboard/monitor: pops one expectation per DONE, otherwise outputs must hold.
  task automatic monitor_step();
    expected_t e;
    expected_t cur;
    cur = {BCD2, BCD1, BCD0, NEG};
    if (!RSTN) begin
      last_out = '0;
    end else if (DONE) begin
      done_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got DONE=1 expected DONE=0 (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("done_bcd2", int'(BCD2), int'(e.bcd2));
        check("done_bcd1", int'(BCD1), int'(e.bcd1));
        check("done_bcd0", int'(BCD0), int'(e.bcd0));
        check("done_neg",  int'(NEG),  int'(e.neg));
        check("done_busy_low", int'(BUSY), 0);
      end
      last_out = cur;
    end else begin
      check("outputs_hold", int'(cur), int'(last_out));
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      monitor_step();
    end
  end

  // One conversion: pulse START for one cycle, scramble BIN afterwards, wait for DONE within a budget.
  task automatic run_conv(input logic [7:0] b, input expected_t e, input string tag);
    int busy_cycles;
    bit seen;
    busy_cycles = 0;
    seen        = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    BIN   = b;
    exp_q.push_back(e);
    @(negedge CLK);
    START = 1'b0;
    BIN   = ~b;
    for (int i = 0; i < 3 * WIDTH && !seen; i++) begin
      if (DONE) seen = 1'b1;
      else begin
        if (BUSY) busy_cycles++;
        @(negedge CLK);
      end
    end
    check({tag, "_done_seen"}, int'(seen), 1);
    check({tag, "_busy_cycles"}, busy_cycles, WIDTH);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * WIDTH && !seen; i++) begin
      @(negedge CLK);
      if (DONE) seen = 1'b1;
    end
    check({tag, "_done_seen"}, int'(seen), 1);
  endtask

  initial begin
    int base;
    int cyc;
    int dones;
    int last_done;
    logic [7:0] r;

    checks     = 0;
    errors     = 0;
    done_count = 0;
    last_out   = '0;
    RSTN       = 1'b1;
    START      = 1'b0;
    BIN        = '0;

    vecs[0] = mk(8'd0,   0, 0, 0, 1'b0);
    vecs[1] = mk(8'd100, 1, 0, 0, 1'b0);
    vecs[2] = mk(8'd9,   0, 0, 9, 1'b0);
    vecs[3] = mk(8'd10,  0, 1, 0, 1'b0);
`ifdef BCD_SIGNED_EN
    vecs[4] = mk(8'h80,  1, 2, 8, 1'b1);
    vecs[5] = mk(8'hFF,  0, 0, 1, 1'b1);
    vecs[6] = mk(8'd127, 1, 2, 7, 1'b0);
    vecs[7] = mk(8'h9C,  1, 0, 0, 1'b1);
`else
    vecs[4] = mk(8'd255, 2, 5, 5, 1'b0);
    vecs[5] = mk(8'hFF,  2, 5, 5, 1'b0);
    vecs[6] = mk(8'd99,  0, 9, 9, 1'b0);
    vecs[7] = mk(8'd128, 1, 2, 8, 1'b0);
`endif

    // Asynchronous reset takes effect before any clock edge.
    #2 RSTN = 1'b0;
    #2;
    check("reset_bcd2", int'(BCD2), 0);
    check("reset_bcd1", int'(BCD1), 0);
    check("reset_bcd0", int'(BCD0), 0);
    check("reset_neg",  int'(NEG),  0);
    check("reset_busy", int'(BUSY), 0);
    check("reset_done", int'(DONE), 0);
    repeat (2) @(posedge CLK);
    #2 RSTN = 1'b1;

    foreach (vecs[i]) begin
      run_conv(vecs[i].bin, vecs[i].exp, $sformatf("vec%0d", i));
      repeat (3) @(negedge CLK);
      check($sformatf("vec%0d_held", i), int'({BCD2, BCD1, BCD0, NEG}), int'(vecs[i].exp));
    end

    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom_range(0, 255));
      run_conv(r, model(r), $sformatf("rand%0d", i));
    end

    // START while busy must be ignored and BIN not re-sampled.
    base = done_count;
    @(negedge CLK);
    START = 1'b1;
    BIN   = 8'd37;
    exp_q.push_back(model(8'd37));
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    START = 1'b1;
    BIN   = 8'd200;
    @(negedge CLK);
    START = 1'b0;
    wait_done("busy_ignore");
    repeat (15) @(negedge CLK);
    check("busy_ignore_done_count", done_count - base, 1);

    // START held high: back-to-back conversions every WIDTH+1 cycles.
    @(negedge CLK);
    START = 1'b1;
    BIN   = 8'd128;
    for (int i = 0; i < 3; i++) exp_q.push_back(model(8'd128));
    cyc       = 0;
    dones     = 0;
    last_done = 0;
    while (dones < 3 && cyc < 60) begin
      @(negedge CLK);
      cyc++;
      if (DONE) begin
        if (dones == 0) check("b2b_first_latency", cyc, WIDTH + 1);
        else            check("b2b_spacing", cyc - last_done, WIDTH + 1);
        last_done = cyc;
        dones++;
      end
    end
    START = 1'b0;
    check("b2b_done_count", dones, 3);
    repeat (4) @(negedge CLK);

    // Reset during iteration 4 aborts without a DONE.
    base = done_count;
    @(negedge CLK);
    START = 1'b1;
    BIN   = 8'd99;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #2 RSTN = 1'b0;
    #1;
    check("abort_bcd2", int'(BCD2), 0);
    check("abort_bcd1", int'(BCD1), 0);
    check("abort_bcd0", int'(BCD0), 0);
    check("abort_neg",  int'(NEG),  0);
    check("abort_busy", int'(BUSY), 0);
    check("abort_done", int'(DONE), 0);
    repeat (2) @(posedge CLK);
    #2 RSTN = 1'b1;
    repeat (12) @(negedge CLK);
    check("abort_no_done", done_count - base, 0);
    run_conv(8'd42, model(8'd42), "after_abort");

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
